// File: rtl/mux_types_pkg.sv
// Shared types and default constants for the pipeline hazard controller.
package mux_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } hzstate_t;

  localparam int REG_W_DEF    = 5;
  localparam int WDOG_MAX_DEF = 255;
  localparam int CNT_W_DEF    = 32;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
// The master drives stage/cache status, the controller answers with stage-register
// enables/flushes, PC enable and sticky status.  There is no valid/ready exchange:
// every signal is level-sensitive and sampled once per rising clock edge.
interface hazard_ctrl_if
  import mux_types_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) ();

  logic             ihit;
  logic             dhit;
  logic             xm_dREN;
  logic             xm_dWEN;
  logic             xm_halt;
  logic             mw_halt;
  logic             ex_redirect;
  logic             dx_dREN;
  logic [REG_W-1:0] dx_wsel;
  logic [REG_W-1:0] fd_rs;
  logic [REG_W-1:0] fd_rt;
  logic             fd_uses_rt;

  logic             pc_en;
  logic             fd_en;
  logic             dx_en;
  logic             xm_en;
  logic             mw_en;
  logic             fd_flush;
  logic             dx_flush;
  logic             halt;
  logic             mem_timeout;
  hzstate_t         state_dbg;

  modport master (
    output ihit, dhit, xm_dREN, xm_dWEN, xm_halt, mw_halt, ex_redirect,
           dx_dREN, dx_wsel, fd_rs, fd_rt, fd_uses_rt,
    input  pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush,
           halt, mem_timeout, state_dbg
  );

  modport slave (
    input  ihit, dhit, xm_dREN, xm_dWEN, xm_halt, mw_halt, ex_redirect,
           dx_dREN, dx_wsel, fd_rs, fd_rt, fd_uses_rt,
    output pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush,
           halt, mem_timeout, state_dbg
  );

endinterface

// File: rtl/hazard_ctrl_perf_cnt.sv
// Stall / flush performance counters, present only when HAZARD_PERF_EN is defined.
// Both counters wrap naturally; the caller masks increments while halted.
`ifdef HAZARD_PERF_EN
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Next-count: add one per qualifying cycle, wrap modulo 2^CNT_W.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_inc) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage-register enables/flushes and PC enable,
// d-mem wait watchdog and sticky halt.
// Optional feature macro: HAZARD_PERF_EN adds stall_cnt/flush_cnt outputs.
module hazard_ctrl
  import mux_types_pkg::*;
#(
  parameter int REG_W    = REG_W_DEF,
  parameter int WDOG_MAX = WDOG_MAX_DEF
`ifdef HAZARD_PERF_EN
  ,
  parameter int CNT_W    = CNT_W_DEF
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  hazard_ctrl_if.slave     hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int              CW       = $clog2(WDOG_MAX + 1);
  localparam logic [CW-1:0]   WDOG_LIM = CW'(WDOG_MAX);

  hzstate_t        state_q, state_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic            timeout_q, timeout_d;

  logic dstall, loaduse, istall;
  logic pc_en_c, fd_en_c, dx_en_c, xm_en_c, mw_en_c, fd_flush_c, dx_flush_c;
  logic redirect_c;

  assign dstall  = (hz.xm_dREN | hz.xm_dWEN) & ~hz.dhit;
  assign loaduse = hz.dx_dREN & (hz.dx_wsel != '0) &
                   ((hz.dx_wsel == hz.fd_rs) | (hz.fd_uses_rt & (hz.dx_wsel == hz.fd_rt)));
  assign istall  = ~hz.ihit;

  // Priority resolution: HALTED > dstall > xm_halt > ex_redirect > loaduse > istall > run.
  always_comb begin
    pc_en_c    = 1'b0;
    fd_en_c    = 1'b0;
    dx_en_c    = 1'b0;
    xm_en_c    = 1'b0;
    mw_en_c    = 1'b0;
    fd_flush_c = 1'b0;
    dx_flush_c = 1'b0;
    redirect_c = 1'b0;
    if (state_q == HALTED) begin
      // everything frozen
    end else if (dstall) begin
      // full freeze while the data access is outstanding
    end else if (hz.xm_halt) begin
      fd_flush_c = 1'b1;
      dx_flush_c = 1'b1;
      xm_en_c    = 1'b1;
      mw_en_c    = 1'b1;
    end else if (hz.ex_redirect) begin
      redirect_c = 1'b1;
      pc_en_c    = 1'b1;
      fd_flush_c = 1'b1;
      dx_flush_c = 1'b1;
      xm_en_c    = 1'b1;
      mw_en_c    = 1'b1;
    end else if (loaduse) begin
      dx_flush_c = 1'b1;
      xm_en_c    = 1'b1;
      mw_en_c    = 1'b1;
    end else if (istall) begin
      fd_flush_c = 1'b1;
      dx_en_c    = 1'b1;
      xm_en_c    = 1'b1;
      mw_en_c    = 1'b1;
    end else begin
      pc_en_c    = 1'b1;
      fd_en_c    = 1'b1;
      dx_en_c    = 1'b1;
      xm_en_c    = 1'b1;
      mw_en_c    = 1'b1;
    end
  end

  // Next state, wait counter and watchdog; a halt in MEM/WB overrides everything.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    timeout_d = timeout_q;
    case (state_q)
      RUN: begin
        wcnt_d = '0;
        if (dstall) state_d = DWAIT;
      end
      DWAIT: begin
        if (wcnt_q != WDOG_LIM) wcnt_d = wcnt_q + 1'b1;
        if (wcnt_d == WDOG_LIM) timeout_d = 1'b1;
        if (hz.dhit) state_d = RUN;
      end
      HALTED: begin
        // sticky until reset
      end
      default: state_d = RUN;
    endcase
    if (hz.mw_halt) state_d = HALTED;
  end

  // State, counter and watchdog registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign hz.pc_en       = pc_en_c;
  assign hz.fd_en       = fd_en_c;
  assign hz.dx_en       = dx_en_c;
  assign hz.xm_en       = xm_en_c;
  assign hz.mw_en       = mw_en_c;
  assign hz.fd_flush    = fd_flush_c;
  assign hz.dx_flush    = dx_flush_c;
  assign hz.halt        = (state_q == HALTED);
  assign hz.mem_timeout = timeout_q;
  assign hz.state_dbg   = state_q;

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .CLK       (CLK),
    .RST       (RST),
    .stall_inc (~pc_en_c & (state_q != HALTED)),
    .flush_inc (redirect_c),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`endif

endmodule
